neuron_seq: RTL and testbench

NEURON_SEQ -- requirements
Module: neuron_seq

---
 rtl/neuron_seq_if.sv | 32 +++
 rtl/neuron_seq.sv | 139 +++++++++++++
 tb/tb_neuron_seq.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/neuron_seq_if.sv
// Bus bundle for the neuron sequencer: start handshake, memory read port,
// MAC operand/accumulator link and the completion/result outputs.
interface neuron_seq_if #(
   parameter int WT_AW = 14
);
   logic                    start;
   logic [3:0]              neuron_idx;
   logic [9:0]              in_addr;
   logic [WT_AW-1:0]        wt_addr;
   logic                    mem_rd;
   logic signed [7:0]       in_data;
   logic signed [7:0]       wt_data;
   logic signed [7:0]       mac_a;
   logic signed [7:0]       mac_b;
   logic                    mac_clr_n;
   logic signed [25:0]      mac_acc;
   logic                    busy;
   logic                    done;
   logic signed [10:0]      result;

   // Environment side: issues requests, supplies memory data and the MAC sum.
   modport master (
      output start, neuron_idx, in_data, wt_data, mac_acc,
      input  in_addr, wt_addr, mem_rd, mac_a, mac_b, mac_clr_n, busy, done, result
   );

   // Sequencer side.
   modport slave (
      input  start, neuron_idx, in_data, wt_data, mac_acc,
      output in_addr, wt_addr, mem_rd, mac_a, mac_b, mac_clr_n, busy, done, result
   );
endinterface

// File: rtl/neuron_seq.sv
// Neuron sequencer: streams NUM_IN input/weight pairs from two synchronous
// memories into an external MAC, then saturates and scales the sum.
// Flow: IDLE -> CLR (clear MAC, fetch element 0) -> FEED (NUM_IN cycles)
//       -> SAT (capture result) -> IDLE with a one-cycle done pulse.
module neuron_seq #(
   parameter int NUM_IN = 784,
   parameter int WT_AW  = 14
) (
   input  logic          clk,
   input  logic          rst_n,
   neuron_seq_if.slave   bus
);
   // Counter holds the element index currently on the address bus (0..NUM_IN).
   localparam int CW = $clog2(NUM_IN + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CLR  = 2'd1,
      S_FEED = 2'd2,
      S_SAT  = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         el_q, el_d;
   logic [WT_AW-1:0]      base_q, base_d;
   logic [WT_AW-1:0]      wt_addr_q, wt_addr_d;
   logic [9:0]            in_addr_q, in_addr_d;
   logic                  mem_rd_q, mem_rd_d;
   logic                  mac_clr_n_q, mac_clr_n_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic signed [10:0]    result_q, result_d;

   // Keep bits 17:7 of the accumulator when it fits in 18 signed bits,
   // otherwise clamp to the 11-bit signed extreme of matching sign.
   function automatic logic signed [10:0] sat_acc(input logic signed [25:0] acc);
      if (acc[25:17] == {9{acc[25]}}) begin
         sat_acc = acc[17:7];
      end else if (acc[25]) begin
         sat_acc = 11'sh400;
      end else begin
         sat_acc = 11'sh3FF;
      end
   endfunction

   // Next-state, counter, address and output-register computation.
   always_comb begin
      state_d  = state_q;
      el_d     = el_q;
      base_d   = base_q;
      done_d   = 1'b0;
      result_d = result_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_CLR;
               el_d    = '0;
               base_d  = WT_AW'(32'(bus.neuron_idx) * 32'(NUM_IN));
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CLR: begin
            state_d = S_FEED;
            el_d    = CW'(1);
         end
         S_FEED: begin
            // el_q == NUM_IN marks the last FEED cycle (element NUM_IN-1 on the MAC).
            if (el_q == CW'(NUM_IN)) begin
               state_d = S_SAT;
            end else begin
               el_d = el_q + CW'(1);
            end
         end
         S_SAT: begin
            state_d  = S_IDLE;
            done_d   = 1'b1;
            result_d = sat_acc(bus.mac_acc);
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      in_addr_d   = 10'(el_d);
      wt_addr_d   = base_d + WT_AW'(el_d);
      mem_rd_d    = (state_d == S_CLR) || ((state_d == S_FEED) && (el_d != CW'(NUM_IN)));
      mac_clr_n_d = (state_d != S_CLR);
      busy_d      = (state_d != S_IDLE);
   end

   // State and output registers; reset abandons any computation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         el_q        <= '0;
         base_q      <= '0;
         wt_addr_q   <= '0;
         in_addr_q   <= 10'd0;
         mem_rd_q    <= 1'b0;
         mac_clr_n_q <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         result_q    <= 11'sd0;
      end else begin
         state_q     <= state_d;
         el_q        <= el_d;
         base_q      <= base_d;
         wt_addr_q   <= wt_addr_d;
         in_addr_q   <= in_addr_d;
         mem_rd_q    <= mem_rd_d;
         mac_clr_n_q <= mac_clr_n_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         result_q    <= result_d;
      end
   end

   // MAC operands pass memory data through only while feeding, so every other
   // edge adds zero to the accumulator.
   always_comb begin
      bus.mac_a = 8'sd0;
      bus.mac_b = 8'sd0;
      if (state_q == S_FEED) begin
         bus.mac_a = bus.in_data;
         bus.mac_b = bus.wt_data;
      end else begin
         bus.mac_a = 8'sd0;
         bus.mac_b = 8'sd0;
      end
   end

   assign bus.in_addr   = in_addr_q;
   assign bus.wt_addr   = wt_addr_q;
   assign bus.mem_rd    = mem_rd_q;
   assign bus.mac_clr_n = mac_clr_n_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.result    = result_q;
endmodule

// File: tb/tb_neuron_seq.sv
// Bench for neuron_seq: a NUM_IN=4 instance on behavioural ROMs and MAC
// (table, hand-written and random runs) plus a NUM_IN=16 instance whose
// sums are large enough to reach the saturation limits.
module tb_neuron_seq;
   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   neuron_seq_if #(.WT_AW(14)) m ();
   neuron_seq_if #(.WT_AW(14)) s ();

   neuron_seq #(.NUM_IN(4), .WT_AW(14)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (m.slave)
   );

   neuron_seq #(.NUM_IN(16), .WT_AW(14)) dut_sat (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (s.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural memories and MACs
   logic signed [7:0] in_mem  [1024];
   logic signed [7:0] wt_mem  [16384];
   logic signed [7:0] in2_mem [1024];
   logic signed [7:0] wt2_mem [16384];
   logic signed [15:0] m_prod, s_prod;

   assign m_prod = m.mac_a * m.mac_b;
   assign s_prod = s.mac_a * s.mac_b;

   // Synchronous-read ROMs for the main instance.
   always_ff @(posedge clk) begin
      if (m.mem_rd) begin
         m.in_data <= in_mem[m.in_addr];
         m.wt_data <= wt_mem[m.wt_addr];
      end
   end

   // Synchronous-read ROMs for the saturation instance.
   always_ff @(posedge clk) begin
      if (s.mem_rd) begin
         s.in_data <= in2_mem[s.in_addr];
         s.wt_data <= wt2_mem[s.wt_addr];
      end
   end

   // MAC for the main instance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)             m.mac_acc <= '0;
      else if (!m.mac_clr_n)  m.mac_acc <= '0;
      else                    m.mac_acc <= m.mac_acc + {{10{m_prod[15]}}, m_prod};
   end

   // MAC for the saturation instance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)             s.mac_acc <= '0;
      else if (!s.mac_clr_n)  s.mac_acc <= '0;
      else                    s.mac_acc <= s.mac_acc + {{10{s_prod[15]}}, s_prod};
   end

   // Reference model: exact integer dot product, then divide by 128 (floor)
   // with clamping to the signed 11-bit range.
   function automatic int sat_ref(input int sum);
      if (sum > 131071)       return 1023;
      else if (sum < -131072) return -1024;
      else                    return sum >>> 7;
   endfunction

   function automatic int model_main(input int idx);
      int sum;
      sum = 0;
      for (int j = 0; j < 4; j++) sum += int'(in_mem[j]) * int'(wt_mem[idx*4 + j]);
      return sat_ref(sum);
   endfunction

   task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Watch for done from cycle c0 through cycle 12 (cycle 1 = CLR).
   task automatic watch_done(input int c0, output int at, output int pulses);
      at = -1;
      pulses = 0;
      for (int c = c0; c <= 12; c++) begin
         if (m.done === 1'b1) begin
            pulses++;
            if (at < 0) at = c;
         end
         @(negedge clk);
      end
   endtask

   task automatic run_main(input int idx, input int exp, input string tag);
      int at, pulses;
      @(negedge clk);
      m.start = 1'b1;
      m.neuron_idx = 4'(idx);
      @(negedge clk);
      m.start = 1'b0;
      chk({tag, "_busy"}, m.busy, 1);
      watch_done(1, at, pulses);
      chk({tag, "_done_cycle"}, at, 7);
      chk({tag, "_done_pulses"}, pulses, 1);
      chk({tag, "_result"}, m.result, exp);
   endtask

   task automatic load_vec(input int idx, input int a0, input int a1, input int a2, input int a3,
                           input int b0, input int b1, input int b2, input int b3);
      in_mem[0] = 8'(a0); in_mem[1] = 8'(a1); in_mem[2] = 8'(a2); in_mem[3] = 8'(a3);
      wt_mem[idx*4+0] = 8'(b0); wt_mem[idx*4+1] = 8'(b1);
      wt_mem[idx*4+2] = 8'(b2); wt_mem[idx*4+3] = 8'(b3);
   endtask

   task automatic run_sat(input int a, input int b, input int exp, input string tag);
      int at;
      for (int j = 0; j < 16; j++) begin
         in2_mem[j] = 8'(a);
         wt2_mem[j] = 8'(b);
      end
      @(negedge clk);
      s.start = 1'b1;
      s.neuron_idx = 4'd0;
      @(negedge clk);
      s.start = 1'b0;
      at = -1;
      for (int c = 1; c <= 24; c++) begin
         if (s.done === 1'b1 && at < 0) at = c;
         @(negedge clk);
      end
      chk({tag, "_done_cycle"}, at, 19);
      chk({tag, "_result"}, s.result, exp);
   endtask

   typedef struct {
      int in_v [4];
      int wt_v [4];
      int idx;
      int exp;
   } vec_t;

   typedef struct {
      int a;
      int b;
      int exp;
   } sat_vec_t;

   vec_t     vecs [8];
   sat_vec_t svecs [8];

   // Safety net so a stuck run still terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int at, pulses, exp_a, exp_b, idx;
      errors = 0;
      checks = 0;
      for (int i = 0; i < 1024; i++) begin in_mem[i] = 8'sd0; in2_mem[i] = 8'sd0; end
      for (int i = 0; i < 16384; i++) begin wt_mem[i] = 8'sd0; wt2_mem[i] = 8'sd0; end

      vecs[0] = '{'{2, -2, -3, 1},          '{5, 5, 8, 0},             0,  -1};
      vecs[1] = '{'{127, 127, 127, 127},    '{127, 127, 127, 127},     1,  504};
      vecs[2] = '{'{126, 126, 126, 126},    '{-100, -100, -100, -100}, 3,  -394};
      vecs[3] = '{'{-128, -128, -128, -128}, '{-128, -128, -128, -128}, 15, 512};
      vecs[4] = '{'{1, 2, 3, 4},            '{10, 20, 30, 40},         9,  2};
      vecs[5] = '{'{-1, 0, 0, 0},           '{1, 0, 0, 0},             0,  -1};
      vecs[6] = '{'{100, -100, 50, -50},    '{1, 1, 1, 1},             5,  0};
      vecs[7] = '{'{127, -128, 127, -128},  '{-128, 127, -128, 127},   12, -508};

      svecs[0] = '{-128, -128, 1023};
      svecs[1] = '{127, -128, -1024};
      svecs[2] = '{-128, -64, 1023};
      svecs[3] = '{-128, 64, -1024};
      svecs[4] = '{-128, 65, -1024};
      svecs[5] = '{90, 91, 1023};
      svecs[6] = '{64, 64, 512};
      svecs[7] = '{-127, 64, -1016};

      rst_n = 1'b0;
      m.start = 1'b0; m.neuron_idx = 4'd0;
      s.start = 1'b0; s.neuron_idx = 4'd0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_busy", m.busy, 0);
      chk("rst_done", m.done, 0);
      chk("rst_mem_rd", m.mem_rd, 0);
      chk("rst_mac_clr_n", m.mac_clr_n, 1);
      chk("rst_result", m.result, 0);
      chk("rst_wt_addr", m.wt_addr, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Table-driven runs
      for (int k = 0; k < 8; k++) begin
         load_vec(vecs[k].idx, vecs[k].in_v[0], vecs[k].in_v[1], vecs[k].in_v[2], vecs[k].in_v[3],
                  vecs[k].wt_v[0], vecs[k].wt_v[1], vecs[k].wt_v[2], vecs[k].wt_v[3]);
         run_main(vecs[k].idx, vecs[k].exp, $sformatf("vec%0d", k));
      end

      // Address sequence for neuron 2; neuron_idx changed mid-run must not matter
      load_vec(2, 11, -7, 33, 90, 3, -4, 5, -6);
      load_vec(5, 11, -7, 33, 90, 100, 100, 100, 100);
      exp_a = model_main(2);
      @(negedge clk);
      m.start = 1'b1;
      m.neuron_idx = 4'd2;
      @(negedge clk);
      m.start = 1'b0;
      m.neuron_idx = 4'd5;
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("addr_wt%0d", c), m.wt_addr, 8 + c);
         chk($sformatf("addr_in%0d", c), m.in_addr, c);
         chk($sformatf("addr_rd%0d", c), m.mem_rd, 1);
         chk($sformatf("addr_clr%0d", c), m.mac_clr_n, (c == 0) ? 0 : 1);
         @(negedge clk);
      end
      chk("addr_last_rd", m.mem_rd, 0);
      chk("addr_last_mac_a", m.mac_a, 90);
      chk("addr_last_mac_b", m.mac_b, -6);
      watch_done(5, at, pulses);
      chk("addr_done_cycle", at, 7);
      chk("addr_result", m.result, exp_a);

      // Start re-pulsed while busy is ignored; start held through done restarts at once
      load_vec(6, -50, 60, -70, 80, 9, 8, -7, 6);
      load_vec(7, -50, 60, -70, 80, -120, 110, -100, 90);
      exp_a = model_main(6);
      exp_b = model_main(7);
      @(negedge clk);
      m.start = 1'b1;
      m.neuron_idx = 4'd6;
      @(negedge clk);
      m.start = 1'b0;
      @(negedge clk);
      m.start = 1'b1;
      m.neuron_idx = 4'd7;
      @(negedge clk);
      m.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("b2b_no_early_done", m.done, 0);
      m.start = 1'b1;
      m.neuron_idx = 4'd7;
      @(negedge clk);
      chk("b2b_first_done", m.done, 1);
      chk("b2b_first_result", m.result, exp_a);
      @(negedge clk);
      m.start = 1'b0;
      chk("b2b_second_busy", m.busy, 1);
      chk("b2b_second_clr", m.mac_clr_n, 0);
      watch_done(1, at, pulses);
      chk("b2b_second_done_cycle", at, 7);
      chk("b2b_second_pulses", pulses, 1);
      chk("b2b_second_result", m.result, exp_b);

      // Reset during FEED
      load_vec(4, 20, 30, 40, 50, 7, 7, 7, 7);
      exp_a = model_main(4);
      @(negedge clk);
      m.start = 1'b1;
      m.neuron_idx = 4'd4;
      @(negedge clk);
      m.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rstfeed_busy", m.busy, 0);
      chk("rstfeed_done", m.done, 0);
      chk("rstfeed_mac_a", m.mac_a, 0);
      chk("rstfeed_mac_b", m.mac_b, 0);
      chk("rstfeed_mac_clr_n", m.mac_clr_n, 1);
      chk("rstfeed_mem_rd", m.mem_rd, 0);
      chk("rstfeed_wt_addr", m.wt_addr, 0);
      chk("rstfeed_result", m.result, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      watch_done(1, at, pulses);
      chk("rstfeed_no_done", pulses, 0);
      chk("rstfeed_idle", m.busy, 0);
      run_main(4, exp_a, "rstfeed_rerun");

      // Random runs against the model
      for (int r = 0; r < 16; r++) begin
         idx = int'($urandom_range(15));
         for (int j = 0; j < 4; j++) begin
            in_mem[j] = 8'($urandom);
            wt_mem[idx*4 + j] = 8'($urandom);
         end
         run_main(idx, model_main(idx), $sformatf("rand%0d", r));
      end

      // Saturation limits on the NUM_IN=16 instance
      for (int k = 0; k < 8; k++) begin
         run_sat(svecs[k].a, svecs[k].b, svecs[k].exp, $sformatf("sat%0d", k));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
